regbank_write_arbiter: RTL and testbench

//  Shares the register bank's single write port (shared data bus + 16 one-hot write enables) among NUM_REQ

---
 rtl/regbank_pkg.sv | 27 ++
 rtl/regbank_write_arbiter_rr.sv | 69 ++++++
 rtl/regbank_write_arbiter.sv | 97 +++++++++
 tb/tb_regbank_write_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank write path: bank geometry,
// index/data typedefs and the one-hot write-enable decoder.
package regbank_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;

    typedef logic [IDX_W-1:0]    idx_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [NUM_REGS-1:0] regvec_t;

    // One-hot decode of a destination index; indices beyond the bank give all-zero.
    function automatic regvec_t onehot_decode(input idx_t idx);
        regvec_t v;
        v = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (int'(idx) == r) begin
                v[r] = 1'b1;
            end else begin
                v[r] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr.sv
// Round-robin arbiter: searches the request vector upward from the rotating
// pointer and grants the first active requester. The pointer moves one past
// the winner whenever a grant is issued and holds otherwise.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_grant_vld
);

    logic [ID_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_found;

    // Priority search starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int v_j;
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        v_j        = 0;
        if (i_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                v_j = int'(r_ptr) + k;
                if (v_j >= NUM_REQ) begin
                    v_j = v_j - NUM_REQ;
                end else begin
                    v_j = v_j;
                end
                if (!w_found && i_req[v_j]) begin
                    w_found       = 1'b1;
                    w_grant[v_j]  = 1'b1;
                    w_grant_id    = ID_W'(v_j);
                end else begin
                    w_found = w_found;
                end
            end
        end else begin
            w_found = 1'b0;
        end
    end

    // Pointer rotates to one past the winner on every grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            if (w_grant_id == ID_W'(NUM_REQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_grant_id + ID_W'(1);
            end
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_id  = w_grant_id;
    assign o_grant_vld = w_found;

endmodule

// File: rtl/regbank_write_arbiter.sv
// Register-bank write-port arbiter. NUM_REQ requesters compete round-robin
// for the single write port; the winner's index and data go through one
// register stage onto the bank's data bus and one-hot enables.
// Optional build macro REGARB_R0_ZERO_EN: writes to index 0 are accepted but
// never enabled, so r0 behaves as a hard-wired zero register.
module regbank_write_arbiter
    import regbank_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*IDX_W-1:0]   i_req_idx,
    input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
    input  logic                       i_stall,
    output logic [DATA_W-1:0]          o_wr_data,
    output logic [NUM_REGS-1:0]        o_reg_enable,
    output logic [NUM_REGS-1:0]        o_pend_busy,
    output logic [ID_W-1:0]            o_grant_id
);

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_xfer;
    logic               w_arb_en;
    idx_t               w_sel_idx;
    data_t              w_sel_data;
    regvec_t            w_dec;

    data_t              r_wr_data;
    regvec_t            r_reg_enable;
    regvec_t            r_pend_busy;
    logic [ID_W-1:0]    r_grant_id;

    // No acceptance while stalled or in reset, so ready drops combinationally.
    assign w_arb_en = !i_stall && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req_valid),
        .i_en        (w_arb_en),
        .o_grant     (w_grant),
        .o_grant_id  (w_grant_id),
        .o_grant_vld (w_xfer)
    );

    assign o_req_ready = w_grant;

    // Select the winner's destination and data and decode the write enable.
    always_comb begin
        w_sel_idx  = i_req_idx[w_grant_id*IDX_W +: IDX_W];
        w_sel_data = i_req_data[w_grant_id*DATA_W +: DATA_W];
        w_dec      = onehot_decode(w_sel_idx);
`ifdef REGARB_R0_ZERO_EN
        if (w_sel_idx == IDX_W'(0)) begin
            w_dec = '0;
        end else begin
            w_dec = w_dec;
        end
`endif
    end

    // Output stage: capture an accepted write; enables clear when idle,
    // bus data and grant id hold their last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_data    <= '0;
            r_reg_enable <= '0;
            r_pend_busy  <= '0;
            r_grant_id   <= '0;
        end else if (w_xfer) begin
            r_wr_data    <= w_sel_data;
            r_reg_enable <= w_dec;
            r_pend_busy  <= w_dec;
            r_grant_id   <= w_grant_id;
        end else begin
            r_wr_data    <= r_wr_data;
            r_reg_enable <= '0;
            r_pend_busy  <= '0;
            r_grant_id   <= r_grant_id;
        end
    end

    // A write already on the stage is discarded in the cycle reset is raised.
    assign o_reg_enable = reset ? '0 : r_reg_enable;
    assign o_pend_busy  = reset ? '0 : r_pend_busy;
    assign o_wr_data    = r_wr_data;
    assign o_grant_id   = r_grant_id;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter. Each step drives inputs, checks
// ready and the output stage, and queues what the output stage must show in
// the next cycle.
module tb_regbank_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [11:0] req_idx;
    logic [47:0] req_data;
    logic        stall;
    logic [15:0] wr_data;
    logic [15:0] reg_enable;
    logic [15:0] pend_busy;
    logic [1:0]  grant_id;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] en;
        logic [15:0] data;
        logic [1:0]  gid;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] hold_data;
    logic [1:0]  hold_gid;

`ifdef REGARB_R0_ZERO_EN
    localparam logic [15:0] R0_EN = 16'h0000;
`else
    localparam logic [15:0] R0_EN = 16'h0001;
`endif

    regbank_write_arbiter #(.NUM_REQ(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_idx    (req_idx),
        .i_req_data   (req_data),
        .i_stall      (stall),
        .o_wr_data    (wr_data),
        .o_reg_enable (reg_enable),
        .o_pend_busy  (pend_busy),
        .o_grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock step: drive, check current outputs, queue next expectation.
    task automatic step(input logic rst, input logic stl, input logic [2:0] vld,
                        input logic [2:0] e_rdy, input logic [15:0] e_en,
                        input logic [15:0] e_data, input logic [1:0] e_gid);
        exp_t cur;
        exp_t nxt;
        reset     = rst;
        stall     = stl;
        req_valid = vld;
        #1;
        total++;
        assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=1", exp_q.size());
        end
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("req_ready",  {13'd0, req_ready}, {13'd0, e_rdy});
            chk("reg_enable", reg_enable, rst ? 16'h0000 : cur.en);
            chk("pend_busy",  pend_busy,  rst ? 16'h0000 : cur.en);
            chk("wr_data",    wr_data,    cur.data);
            chk("grant_id",   {14'd0, grant_id}, {14'd0, cur.gid});
        end else begin
            cur = '0;
        end
        if (rst) begin
            hold_data = 16'h0000;
            hold_gid  = 2'd0;
            nxt = '{en: 16'h0000, data: 16'h0000, gid: 2'd0};
        end else if (e_rdy != 3'b000) begin
            hold_data = e_data;
            hold_gid  = e_gid;
            nxt = '{en: e_en, data: e_data, gid: e_gid};
        end else begin
            nxt = '{en: 16'h0000, data: hold_data, gid: hold_gid};
        end
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = 3'b000;
        req_idx   = 12'h000;
        req_data  = 48'h0;
        hold_data = 16'h0000;
        hold_gid  = 2'd0;
        @(posedge clk);
        #1;
        exp_q.push_back('{en: 16'h0000, data: 16'h0000, gid: 2'd0});

        // T1: reset held with all requesters valid
        step(1'b1, 1'b0, 3'b111, 3'b000, 16'h0000, 16'h0000, 2'd0);
        step(1'b1, 1'b0, 3'b111, 3'b000, 16'h0000, 16'h0000, 2'd0);

        // T2: single write idx 5 from req0
        req_idx[3:0]   = 4'd5;
        req_data[15:0] = 16'hBEEF;
        step(1'b0, 1'b0, 3'b001, 3'b001, 16'h0020, 16'hBEEF, 2'd0);
        step(1'b0, 1'b0, 3'b000, 3'b000, 16'h0000, 16'h0000, 2'd0);
        step(1'b0, 1'b0, 3'b000, 3'b000, 16'h0000, 16'h0000, 2'd0);

        // T3: round robin from a fresh pointer
        step(1'b1, 1'b0, 3'b000, 3'b000, 16'h0000, 16'h0000, 2'd0);
        req_idx  = {4'd3, 4'd2, 4'd1};
        req_data = {16'hA2A2, 16'hA1A1, 16'hA0A0};
        for (int n = 0; n < 2; n++) begin
            step(1'b0, 1'b0, 3'b111, 3'b001, 16'h0002, 16'hA0A0, 2'd0);
            step(1'b0, 1'b0, 3'b111, 3'b010, 16'h0004, 16'hA1A1, 2'd1);
            step(1'b0, 1'b0, 3'b111, 3'b100, 16'h0008, 16'hA2A2, 2'd2);
        end
        step(1'b0, 1'b0, 3'b000, 3'b000, 16'h0000, 16'h0000, 2'd0);

        // T4: stall blocks req1, then it is accepted
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b1, 3'b010, 3'b000, 16'h0000, 16'h0000, 2'd0);
        end
        step(1'b0, 1'b0, 3'b010, 3'b010, 16'h0004, 16'hA1A1, 2'd1);
        step(1'b0, 1'b0, 3'b000, 3'b000, 16'h0000, 16'h0000, 2'd0);
        // pointer now 2: req0 wins over req1
        step(1'b0, 1'b0, 3'b011, 3'b001, 16'h0002, 16'hA0A0, 2'd0);

        // T5: edge indices and same destination back to back
        req_idx  = {4'd15, 4'd15, 4'd0};
        req_data = {16'h6666, 16'h5555, 16'h1234};
        step(1'b0, 1'b0, 3'b001, 3'b001, R0_EN,   16'h1234, 2'd0);
        step(1'b0, 1'b0, 3'b010, 3'b010, 16'h8000, 16'h5555, 2'd1);
        step(1'b0, 1'b0, 3'b100, 3'b100, 16'h8000, 16'h6666, 2'd2);
        step(1'b0, 1'b0, 3'b000, 3'b000, 16'h0000, 16'h0000, 2'd0);

        // T6: reset while a write is on the output stage
        req_idx  = {4'd9, 4'd3, 4'd7};
        req_data = {16'h9999, 16'h3333, 16'h7777};
        step(1'b0, 1'b0, 3'b010, 3'b010, 16'h0008, 16'h3333, 2'd1);
        step(1'b1, 1'b0, 3'b000, 3'b000, 16'h0000, 16'h0000, 2'd0);
        step(1'b0, 1'b0, 3'b111, 3'b001, 16'h0080, 16'h7777, 2'd0);
        step(1'b0, 1'b0, 3'b000, 3'b000, 16'h0000, 16'h0000, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
